board_renderer: RTL

BOARD_RENDERER -- requirements
Module: board_renderer

---
 rtl/tetris_pkg.sv | 38 +++
 rtl/board_store.sv | 72 +++++++
 rtl/board_renderer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared board geometry, playfield bounds, palette and clear-FSM state type
// for the Tetris board store and renderer.
package tetris_pkg;

   localparam int BOARD_W = 10;
   localparam int BOARD_H = 20;

   localparam logic [9:0] FIELD_X0 = 10'd203;
   localparam logic [9:0] FIELD_X1 = 10'd433;
   localparam logic [9:0] FIELD_Y0 = 10'd11;
   localparam logic [9:0] FIELD_Y1 = 10'd471;

   localparam logic [11:0] COLOR_BG    = 12'h112;
   localparam logic [11:0] COLOR_FRAME = 12'hFFF;
   localparam logic [11:0] COLOR_GRID  = 12'h444;
   localparam logic [11:0] COLOR_BLACK = 12'h000;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      TOP
   } clearState_t;

   // Code 0 is an empty cell and renders black; 1..7 are the piece colours.
   function automatic logic [11:0] paletteColor(input logic [2:0] code);
      case (code)
         3'd1:    return 12'h0FF;
         3'd2:    return 12'hFF0;
         3'd3:    return 12'hA0F;
         3'd4:    return 12'h0F0;
         3'd5:    return 12'hF00;
         3'd6:    return 12'h00F;
         3'd7:    return 12'hF80;
         default: return COLOR_BLACK;
      endcase
   endfunction

endpackage

// File: rtl/board_store.sv
// 10x20 cell store with a game-logic write port, a row-clear FSM that shifts
// the rows above the cleared one down, and a combinational read port.
module board_store
   import tetris_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_wrEn,
   input  logic [3:0] i_wrX,
   input  logic [4:0] i_wrY,
   input  logic [2:0] i_wrColor,
   input  logic       i_clearReq,
   input  logic [4:0] i_clearIdx,
   input  logic [3:0] i_rdX,
   input  logic [4:0] i_rdY,
   output logic [2:0] o_rdColor,
   output logic       o_busy,
   output logic       o_clearDone
);

   logic [3*BOARD_W-1:0] r_rows [BOARD_H];
   clearState_t          r_state;
   logic [4:0]           r_row;
   logic                 r_busy;
   logic                 r_clearDone;

   // A clear request wins over a write issued in the same idle cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < BOARD_H; i++) r_rows[i] <= '0;
         r_state     <= IDLE;
         r_row       <= '0;
         r_busy      <= 1'b0;
         r_clearDone <= 1'b0;
      end else begin
         r_clearDone <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_clearReq && i_clearIdx <= 5'(BOARD_H - 1)) begin
                  r_row   <= i_clearIdx;
                  r_busy  <= 1'b1;
                  r_state <= (i_clearIdx == 5'd0) ? TOP : SHIFT;
               end else if (i_wrEn && i_wrX <= 4'(BOARD_W - 1) && i_wrY <= 5'(BOARD_H - 1)) begin
                  r_rows[i_wrY][i_wrX*3 +: 3] <= i_wrColor;
               end
            end
            SHIFT: begin
               r_rows[r_row] <= r_rows[r_row - 5'd1];
               r_row         <= r_row - 5'd1;
               if (r_row == 5'd1) r_state <= TOP;
            end
            TOP: begin
               r_rows[0]   <= '0;
               r_clearDone <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_comb begin
      o_rdColor = '0;
      if (i_rdX <= 4'(BOARD_W - 1) && i_rdY <= 5'(BOARD_H - 1))
         o_rdColor = r_rows[i_rdY][i_rdX*3 +: 3];
   end

   assign o_busy      = r_busy;
   assign o_clearDone = r_clearDone;

endmodule

// File: rtl/board_renderer.sv
// Two-stage pixel pipeline that overlays frame, grid, active piece and stored
// cells onto the video stream, with sync signals delayed to match.
module board_renderer
   import tetris_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        ce,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic [3:0]  x_b,
   input  logic [4:0]  y_b,
   input  logic        border_x,
   input  logic        border_y,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        video_on_in,
   input  logic        wr_en,
   input  logic [3:0]  wr_x,
   input  logic [4:0]  wr_y,
   input  logic [2:0]  wr_color,
   input  logic        row_clear_req,
   input  logic [4:0]  row_clear_idx,
   input  logic [35:0] piece_cells,
   input  logic [2:0]  piece_color,
   input  logic        piece_en,
   output logic        busy,
   output logic        clear_done,
   output logic [11:0] rgb,
   output logic        hsync,
   output logic        vsync
);

   logic [2:0]  w_cellCode;
   logic        w_pieceHit;
   logic        w_inField;
   logic        w_frame;
   logic [11:0] w_rgb;

   logic [9:0]  r_xD, r_yD;
   logic        r_hs1, r_vs1, r_von1;
   logic        r_hs2, r_vs2, r_von2;
   logic        r_inField, r_frame, r_grid, r_hit;
   logic [2:0]  r_code;
   logic [11:0] r_rgb;
   logic        r_hsync, r_vsync;

   board_store u_store (
      .clk         (clk),
      .reset       (reset),
      .i_wrEn      (wr_en),
      .i_wrX       (wr_x),
      .i_wrY       (wr_y),
      .i_wrColor   (wr_color),
      .i_clearReq  (row_clear_req),
      .i_clearIdx  (row_clear_idx),
      .i_rdX       (x_b),
      .i_rdY       (y_b),
      .o_rdColor   (w_cellCode),
      .o_busy      (busy),
      .o_clearDone (clear_done)
   );

   always_comb begin
      w_pieceHit = 1'b0;
      if (piece_en)
         for (int i = 0; i < 4; i++)
            if (piece_cells[9*i +: 9] == {x_b, y_b}) w_pieceHit = 1'b1;
   end

   // Field tests use the coordinate delayed one tick so it lines up with x_b/y_b.
   assign w_inField = (r_xD >= FIELD_X0) && (r_xD <= FIELD_X1) &&
                      (r_yD >= FIELD_Y0) && (r_yD <= FIELD_Y1);
   assign w_frame   = (r_xD == FIELD_X0) || (r_xD == FIELD_X1) ||
                      (r_yD == FIELD_Y0) || (r_yD == FIELD_Y1);

   always_comb begin
      w_rgb = COLOR_BLACK;
      if (!r_von2)         w_rgb = COLOR_BLACK;
      else if (!r_inField) w_rgb = COLOR_BG;
      else if (r_frame)    w_rgb = COLOR_FRAME;
      else if (r_grid)     w_rgb = COLOR_GRID;
      else if (r_hit)      w_rgb = paletteColor(piece_color);
      else                 w_rgb = paletteColor(r_code);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_xD      <= '0;
         r_yD      <= '0;
         r_hs1     <= 1'b1;
         r_vs1     <= 1'b1;
         r_von1    <= 1'b0;
         r_hs2     <= 1'b1;
         r_vs2     <= 1'b1;
         r_von2    <= 1'b0;
         r_inField <= 1'b0;
         r_frame   <= 1'b0;
         r_grid    <= 1'b0;
         r_hit     <= 1'b0;
         r_code    <= '0;
         r_rgb     <= COLOR_BLACK;
         r_hsync   <= 1'b1;
         r_vsync   <= 1'b1;
      end else if (ce) begin
         r_xD      <= x;
         r_yD      <= y;
         r_hs1     <= hsync_in;
         r_vs1     <= vsync_in;
         r_von1    <= video_on_in;
         r_inField <= w_inField;
         r_frame   <= w_frame;
         r_grid    <= border_x | border_y;
         r_hit     <= w_pieceHit;
         r_code    <= w_cellCode;
         r_hs2     <= r_hs1;
         r_vs2     <= r_vs1;
         r_von2    <= r_von1;
         r_rgb     <= w_rgb;
         r_hsync   <= r_hs2;
         r_vsync   <= r_vs2;
      end
   end

   assign rgb   = r_rgb;
   assign hsync = r_hsync;
   assign vsync = r_vsync;

endmodule
